aes_skid_pipe: RTL and testbench



---
 rtl/aes_pkg.sv | 13 +
 rtl/aes_skid_stage.sv | 83 ++++++++
 rtl/aes_skid_pipe.sv | 85 ++++++++
 tb/tb_aes_skid_pipe.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES datapath width and skid-stage state encoding
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  // Encoded as {m_valid, s_valid} so the valid bits fall straight out of the state.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b10,
    FULL  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/aes_skid_stage.sv
// rtl/aes_skid_stage.sv - one main+skid elastic register stage with registered in_ready
module aes_skid_stage
  import aes_pkg::*;
#(
  parameter int WIDTH = AES_BLOCK_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output skid_state_e      state
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] m_data, m_data_d;
  logic [WIDTH-1:0] s_data, s_data_d;
  logic             rdy_q;
  logic             in_fire, out_fire;

  assign in_ready  = rdy_q;
  assign out_valid = state_q[1];
  assign out_data  = m_data;
  assign state     = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      m_data  <= '0;
      s_data  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_data  <= m_data_d;
      s_data  <= s_data_d;
      rdy_q   <= ~state_d[0];
    end
  end

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data;
    s_data_d = s_data;
    in_fire  = in_valid & rdy_q;
    out_fire = state_q[1] & out_ready;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d  = BUSY;
          m_data_d = in_data;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          m_data_d = in_data;
        end else if (in_fire) begin
          state_d  = FULL;
          s_data_d = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d  = BUSY;
          m_data_d = s_data;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops only the valids; held data is left in place.
    if (flush) begin
      state_d  = EMPTY;
      m_data_d = m_data;
      s_data_d = s_data;
    end
  end

endmodule

// File: rtl/aes_skid_pipe.sv
// rtl/aes_skid_pipe.sv - chain of skid stages between AES round units with occupancy count
module aes_skid_pipe
  import aes_pkg::*;
#(
  parameter int WIDTH  = AES_BLOCK_W,
  parameter int STAGES = 1,
  parameter int CNT_W  = $clog2(2*STAGES+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  logic [STAGES:0]  v;
  logic [STAGES:0]  r;
  logic [WIDTH-1:0] d [STAGES+1];
  skid_state_e      st [STAGES];
  logic             in_fire, out_fire;
  logic [CNT_W-1:0] occ;

  assign v[0]      = in_valid;
  assign d[0]      = in_data;
  assign in_ready  = r[0];
  assign out_valid = v[STAGES];
  assign out_data  = d[STAGES];
  assign r[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    aes_skid_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (v[k]),
      .in_data  (d[k]),
      .in_ready (r[k]),
      .out_valid(v[k+1]),
      .out_data (d[k+1]),
      .out_ready(r[k+1]),
      .state    (st[k])
    );
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= '0;
    end else if (in_fire && !out_fire) begin
      count <= count + CNT_W'(1);
    end else if (out_fire && !in_fire) begin
      count <= count - CNT_W'(1);
    end
  end

  always_comb begin
    occ = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ = occ + CNT_W'(st[k][1]) + CNT_W'(st[k][0]);
    end
  end

  a_out_hold: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

  a_count_max: assert property (@(posedge clk) disable iff (reset)
    count <= CNT_W'(2*STAGES));

  a_no_overflow: assert property (@(posedge clk) disable iff (reset || flush)
    !(in_fire && !out_fire && count == CNT_W'(2*STAGES)));

  a_no_underflow: assert property (@(posedge clk) disable iff (reset || flush)
    !(out_fire && !in_fire && count == '0));

  a_count_occ: assert property (@(posedge clk) disable iff (reset)
    count == occ);

endmodule

// File: tb/tb_aes_skid_pipe.sv
// tb/tb_aes_skid_pipe.sv - directed and scoreboard checks on STAGES=1,2,3 instances sharing stimulus
module tb_aes_skid_pipe;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic [127:0] in_data;

  logic         ir1, ov1, ir2, ov2, ir3, ov3;
  logic [127:0] od1, od2, od3;
  logic [1:0]   c1;
  logic [2:0]   c2, c3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_skid_pipe #(.STAGES(1)) u1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_ready(out_ready), .count(c1));
  aes_skid_pipe #(.STAGES(2)) u2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir2), .out_valid(ov2), .out_data(od2), .out_ready(out_ready), .count(c2));
  aes_skid_pipe #(.STAGES(3)) u3 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir3), .out_valid(ov3), .out_data(od3), .out_ready(out_ready), .count(c3));

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  logic [127:0] w [20];
  logic [127:0] q1 [$];
  logic [127:0] q3 [$];
  logic [127:0] exp_word;
  int           exp_cnt;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = '1; out_ready = 1'b1;

    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ov", ov1, 0);
      check("rst_od", od1, 0);
      check("rst_cnt", c1, 0);
      check("rst_ir", ir1, 0);
    end
    reset = 1'b0; in_valid = 1'b0;
    tick();
    check("rst_rel_ir1", ir1, 1);
    check("rst_rel_ir2", ir2, 1);

    // Streaming through two stages: word k shows on out_* after the edge following its accept.
    for (int i = 0; i < 20; i++) w[i] = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1;
    for (int k = 0; k < 22; k++) begin
      if (k < 20) begin
        in_valid = 1'b1; in_data = w[k];
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (k < 20) check("str_ir", ir2, 1);
      if (k >= 1 && k <= 20) begin
        check("str_ov", ov2, 1);
        check("str_od", od2, w[k-1]);
      end else begin
        check("str_ov_idle", ov2, 0);
      end
      exp_cnt = (k == 0 || k == 20) ? 1 : (k == 21 ? 0 : 2);
      check("str_cnt", c2, exp_cnt);
    end

    // Stall a single stage
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = {4{32'hAAAAAAAA}};
    tick();
    check("stall_ir_a", ir1, 1);
    check("stall_cnt_a", c1, 1);
    in_data = {4{32'h55555555}};
    tick();
    check("stall_ir_full", ir1, 0);
    check("stall_cnt_full", c1, 2);
    check("stall_ov", ov1, 1);
    check("stall_od", od1, {4{32'hAAAAAAAA}});
    in_data = {4{32'hDEADBEEF}};
    tick();
    tick();
    check("stall_hold_ir", ir1, 0);
    check("stall_hold_cnt", c1, 2);
    check("stall_hold_od", od1, {4{32'hAAAAAAAA}});
    out_ready = 1'b1;
    tick();
    check("rel_od_5555", od1, {4{32'h55555555}});
    check("rel_ir", ir1, 1);
    check("rel_cnt1", c1, 1);
    tick();
    check("rel_od_dead", od1, {4{32'hDEADBEEF}});
    check("rel_cnt2", c1, 1);
    in_valid = 1'b0;
    tick();
    check("rel_ov_empty", ov1, 0);
    check("rel_cnt0", c1, 0);

    // Flush with a concurrent in-fire on the deeper instance
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = {4{32'h11111111}};
    tick();
    in_data = {4{32'h22222222}};
    tick();
    check("fl_u1_full", ir1, 0);
    check("fl_u3_ready", ir3, 1);
    in_data = {4{32'hCAFEF00D}};
    flush = 1'b1;
    tick();
    check("fl_ov1", ov1, 0);
    check("fl_cnt1", c1, 0);
    check("fl_ir1", ir1, 1);
    check("fl_ov3", ov3, 0);
    check("fl_cnt3", c3, 0);
    check("fl_ir3", ir3, 1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("fl_no_cafe1", ov1, 0);
      check("fl_no_cafe3", ov3, 0);
    end

    // Reset beats flush mid-stream
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = 128'(i);
      tick();
    end
    in_data = 128'h4;
    reset = 1'b1; flush = 1'b1;
    tick();
    check("rp_ir1", ir1, 0);
    check("rp_ov1", ov1, 0);
    check("rp_od1", od1, 0);
    check("rp_cnt1", c1, 0);
    check("rp_ir3", ir3, 0);
    check("rp_ov3", ov3, 0);
    check("rp_cnt3", c3, 0);
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick();
    check("rp_rel_ir1", ir1, 1);

    // Random soak with scoreboards for STAGES=1 and STAGES=3
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      if (ov1 && out_ready) begin
        if (q1.size() == 0) check("soak1_extra", 1, 0);
        else begin
          exp_word = q1.pop_front();
          check("soak1_data", od1, exp_word);
        end
      end
      if (ov3 && out_ready) begin
        if (q3.size() == 0) check("soak3_extra", 1, 0);
        else begin
          exp_word = q3.pop_front();
          check("soak3_data", od3, exp_word);
        end
      end
      if (in_valid && ir1) q1.push_back(in_data);
      if (in_valid && ir3) q3.push_back(in_data);
      tick();
    end
    check("soak1_cnt", c1, q1.size());
    check("soak3_cnt", c3, q3.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
